// File: rtl/ef_pwmdt_pkg.sv
// Shared types and constants for the PWM dead-time inserter: FSM states, APB offsets, read default.
// Pure declarations; no latency or flow control involved.
package ef_pwmdt_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_L_ON  = 3'd1,
    ST_DT_LH = 3'd2,
    ST_H_ON  = 3'd3,
    ST_DT_HL = 3'd4,
    ST_FAULT = 3'd5
  } pwmdt_state_e;

  localparam logic [31:0] ADDR_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DT    = 32'h0000_0004;
  localparam logic [31:0] ADDR_STAT  = 32'h0000_0008;
  localparam logic [31:0] ADDR_RIS   = 32'h0000_000C;
  localparam logic [31:0] ADDR_IM    = 32'h0000_0010;
  localparam logic [31:0] ADDR_ICR   = 32'h0000_0014;
  localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

  // A zero dead time still gets one blanking cycle so the two switches never overlap.
  function automatic logic [7:0] dt_load(input logic [7:0] dt);
    return (dt == 8'd0) ? 8'd1 : dt;
  endfunction

endpackage

// File: rtl/ef_pwm_deadtime_apb_if.sv
// APB3 completer bundle for the PWM dead-time block.
// No storage; PREADY is always high so every transfer completes without wait states.
interface ef_pwm_deadtime_apb_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/ef_pwmdt_core.sv
// Dead-time FSM with blanking counter and optional fault path (EF_PWMDT_FAULT_EN).
// Registered outputs, one cycle after pwm_in; fault reaches the outputs 3 cycles after fault_in; no backpressure.
module ef_pwmdt_core
  import ef_pwmdt_pkg::*;
(
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         en_i,
  input  logic [7:0]   dt_rise_i,
  input  logic [7:0]   dt_fall_i,
  input  logic         pwm_in_i,
`ifdef EF_PWMDT_FAULT_EN
  input  logic         fault_in_i,
  input  logic         icr_clr_i,
  output logic         fault_sync_o,
`endif
  output pwmdt_state_e state_o,
  output logic         pwm_h_o,
  output logic         pwm_l_o
);

  pwmdt_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         pwm_h_q, pwm_l_q;

`ifdef EF_PWMDT_FAULT_EN
  logic fault_s1_q, fault_s2_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fault_s1_q <= 1'b0;
      fault_s2_q <= 1'b0;
    end else begin
      fault_s1_q <= fault_in_i;
      fault_s2_q <= fault_s1_q;
    end
  end

  assign fault_sync_o = fault_s2_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          if (pwm_in_i) begin
            state_d = ST_DT_LH;
            cnt_d   = dt_load(dt_rise_i);
          end else begin
            state_d = ST_DT_HL;
            cnt_d   = dt_load(dt_fall_i);
          end
        end
      end
      ST_L_ON: begin
        if (pwm_in_i) begin
          state_d = ST_DT_LH;
          cnt_d   = dt_load(dt_rise_i);
        end
      end
      ST_DT_LH: begin
        if (!pwm_in_i)          state_d = ST_L_ON;
        else if (cnt_q <= 8'd1) state_d = ST_H_ON;
        else                    cnt_d   = cnt_q - 8'd1;
      end
      ST_H_ON: begin
        if (!pwm_in_i) begin
          state_d = ST_DT_HL;
          cnt_d   = dt_load(dt_fall_i);
        end
      end
      ST_DT_HL: begin
        if (pwm_in_i)           state_d = ST_H_ON;
        else if (cnt_q <= 8'd1) state_d = ST_L_ON;
        else                    cnt_d   = cnt_q - 8'd1;
      end
`ifdef EF_PWMDT_FAULT_EN
      ST_FAULT: begin
        if (icr_clr_i && !fault_s2_q) state_d = ST_OFF;
      end
`else
      ST_FAULT: state_d = ST_OFF;
`endif
      default: state_d = ST_OFF;
    endcase

    // Disable wins over pwm_in but cannot release a latched fault.
    if (!en_i && state_q != ST_FAULT) state_d = ST_OFF;
`ifdef EF_PWMDT_FAULT_EN
    if (fault_s2_q) state_d = ST_FAULT;
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_h_q <= (state_d == ST_H_ON);
      pwm_l_q <= (state_d == ST_L_ON);
    end
  end

  assign state_o = state_q;
  assign pwm_h_o = pwm_h_q;
  assign pwm_l_o = pwm_l_q;

endmodule

// File: rtl/ef_pwm_deadtime_apb.sv
// APB register front end for the PWM dead-time inserter; fault support via EF_PWMDT_FAULT_EN.
// Zero-wait-state APB (PREADY tied high); reads are combinational from PADDR; no backpressure.
module ef_pwm_deadtime_apb
  import ef_pwmdt_pkg::*;
(
  input  logic                        PCLK,
  input  logic                        PRESETn,
  ef_pwm_deadtime_apb_if.slave        apb,
  input  logic                        pwm_in,
`ifdef EF_PWMDT_FAULT_EN
  input  logic                        fault_in,
`endif
  output logic                        pwm_h,
  output logic                        pwm_l,
  output logic                        irq
);

  logic         en_q;
  logic [15:0]  dt_q;
  logic         im_q;
  logic         ris_bit;
  logic         wr_en;
  logic [31:0]  rdata;
  pwmdt_state_e state;
  logic         unused_wdata;

  assign wr_en        = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign unused_wdata = ^apb.PWDATA[31:16];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q <= 1'b0;
      dt_q <= 16'd0;
      im_q <= 1'b0;
    end else if (wr_en) begin
      if (apb.PADDR == ADDR_CTRL) en_q <= apb.PWDATA[0];
      if (apb.PADDR == ADDR_DT)   dt_q <= apb.PWDATA[15:0];
      if (apb.PADDR == ADDR_IM)   im_q <= apb.PWDATA[0];
    end
  end

`ifdef EF_PWMDT_FAULT_EN
  logic icr_q;
  logic ris_q;
  logic fault_sync;

  // ICR is a one-cycle pulse; a still-present fault re-sets RIS over the clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      icr_q <= 1'b0;
      ris_q <= 1'b0;
    end else begin
      icr_q <= wr_en && (apb.PADDR == ADDR_ICR) && apb.PWDATA[0];
      if (fault_sync)  ris_q <= 1'b1;
      else if (icr_q)  ris_q <= 1'b0;
    end
  end

  assign ris_bit = ris_q;
  assign irq     = ris_q & im_q;
`else
  assign ris_bit = 1'b0;
  assign irq     = 1'b0;
`endif

  ef_pwmdt_core u_core (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .en_i         (en_q),
    .dt_rise_i    (dt_q[7:0]),
    .dt_fall_i    (dt_q[15:8]),
    .pwm_in_i     (pwm_in),
`ifdef EF_PWMDT_FAULT_EN
    .fault_in_i   (fault_in),
    .icr_clr_i    (icr_q),
    .fault_sync_o (fault_sync),
`endif
    .state_o      (state),
    .pwm_h_o      (pwm_h),
    .pwm_l_o      (pwm_l)
  );

  always_comb begin
    rdata = RD_DEFAULT;
    case (apb.PADDR)
      ADDR_CTRL: rdata = {31'd0, en_q};
      ADDR_DT:   rdata = {16'd0, dt_q};
      ADDR_STAT: rdata = {29'd0, state};
      ADDR_RIS:  rdata = {31'd0, ris_bit};
      ADDR_IM:   rdata = {31'd0, im_q};
      ADDR_ICR:  rdata = 32'd0;
      default:   rdata = RD_DEFAULT;
    endcase
  end

  assign apb.PRDATA = rdata;
  assign apb.PREADY = 1'b1;

endmodule

// File: tb/tb_ef_pwm_deadtime_apb.sv
// Bench for ef_pwm_deadtime_apb: directed dead-time/abort/fault/read cases plus a long random run,
// all checked against a cycle-level behavioural model of the spec rules.
module tb_ef_pwm_deadtime_apb;

  logic PCLK = 1'b0;
  logic PRESETn;
  logic pwm_in_tb;
  logic fault_in_tb;
  logic pwm_h, pwm_l, irq;

  int n_chk = 0;
  int n_bad = 0;
  bit mchk  = 1'b0;

  ef_pwm_deadtime_apb_if apb ();

  ef_pwm_deadtime_apb dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (apb.slave),
    .pwm_in   (pwm_in_tb),
`ifdef EF_PWMDT_FAULT_EN
    .fault_in (fault_in_tb),
`endif
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: register copies plus "which side is selected / how much blanking remains".
  bit       m_en, m_im, m_ris, m_icr, m_faulted;
  bit [7:0] m_rise, m_fall;
  bit       m_on, m_side;
  int       m_left;
  bit       m_f1, m_f2;

  function automatic int blank(input bit side);
    int v;
    v = side ? int'(m_rise) : int'(m_fall);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_ris = 0; m_icr = 0; m_faulted = 0;
    m_rise = 0; m_fall = 0; m_on = 0; m_side = 0; m_left = 0;
    m_f1 = 0; m_f2 = 0;
  endtask

  task automatic model_edge();
    bit sync, icr_now, wr, pwm;
    pwm     = pwm_in_tb;
    sync    = m_f2;
    m_f2    = m_f1;
    m_f1    = fault_in_tb;
    icr_now = m_icr;
    wr      = apb.PSEL && apb.PENABLE && apb.PWRITE;
    m_icr   = wr && (apb.PADDR == 32'h14) && apb.PWDATA[0];
    if (sync) begin
      m_faulted = 1; m_on = 0;
    end else if (m_faulted) begin
      if (icr_now) begin m_faulted = 0; m_on = 0; end
    end else if (!m_en) begin
      m_on = 0;
    end else if (!m_on) begin
      m_on = 1; m_side = pwm; m_left = blank(pwm);
    end else if (pwm != m_side) begin
      // New edge while conducting starts blanking; during blanking it cancels it.
      m_left = (m_left == 0) ? blank(pwm) : 0;
      m_side = pwm;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end
    if (sync)         m_ris = 1;
    else if (icr_now) m_ris = 0;
    if (wr) begin
      if (apb.PADDR == 32'h00) m_en = apb.PWDATA[0];
      if (apb.PADDR == 32'h04) begin m_rise = apb.PWDATA[7:0]; m_fall = apb.PWDATA[15:8]; end
      if (apb.PADDR == 32'h10) m_im = apb.PWDATA[0];
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit eh, el;
    @(posedge PCLK);
    model_edge();
    #1;
    if (mchk) begin
      eh = !m_faulted && m_on && (m_left == 0) && m_side;
      el = !m_faulted && m_on && (m_left == 0) && !m_side;
      check_eq("model_pwm_h", {31'd0, pwm_h}, {31'd0, eh});
      check_eq("model_pwm_l", {31'd0, pwm_l}, {31'd0, el});
      check_eq("model_irq", {31'd0, irq}, {31'd0, m_ris & m_im});
      check_eq("no_overlap", {31'd0, pwm_h & pwm_l}, 32'd0);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    tick();
    apb.PENABLE = 1'b1;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    apb.PADDR = a; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    tick();
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Count blanking cycles after pwm_in has been changed, then check which side came on.
  task automatic measure_dead(input string tag, input int exp_n, input bit exp_high);
    int n;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (pwm_h || pwm_l) break;
      n++;
    end
    check_eq({tag, "_cycles"}, n, exp_n);
    check_eq({tag, "_side"}, {31'd0, exp_high ? pwm_h : pwm_l}, 32'd1);
  endtask

  task automatic wait_out(input string tag, input bit high);
    int k;
    for (k = 0; k < 300; k++) begin
      if ((high ? pwm_h : pwm_l) == 1'b1) break;
      tick();
    end
    check_eq({tag, "_reached"}, {31'd0, high ? pwm_h : pwm_l}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    bit          h_seen;
    int          r;
    PRESETn = 1'b0; pwm_in_tb = 1'b0; fault_in_tb = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    model_reset();
    #21;
    check_eq("rst_pwm_h", {31'd0, pwm_h}, 32'd0);
    check_eq("rst_pwm_l", {31'd0, pwm_l}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    #1 PRESETn = 1'b1;
    mchk = 1'b1;
    apb_read(32'h00, rd); check_eq("rst_ctrl", rd, 32'd0);
    apb_read(32'h04, rd); check_eq("rst_dt", rd, 32'd0);
    apb_read(32'h08, rd); check_eq("rst_stat", rd, 32'd0);
    apb_read(32'h0C, rd); check_eq("rst_ris", rd, 32'd0);
    apb_read(32'h10, rd); check_eq("rst_im", rd, 32'd0);

    // Dead-time timing with dt_rise=4, dt_fall=2.
    apb_write(32'h04, 32'h0000_0204);
    apb_write(32'h00, 32'h1);
    wait_out("l_on", 1'b0);
    pwm_in_tb = 1'b1; measure_dead("dt_rise4", 4, 1'b1);
    pwm_in_tb = 1'b0; measure_dead("dt_fall2", 2, 1'b0);

    // Zero dead time still blanks one cycle.
    apb_write(32'h04, 32'h0000_0200);
    pwm_in_tb = 1'b1; measure_dead("dt_rise0", 1, 1'b1);
    pwm_in_tb = 1'b0; measure_dead("dt_fall2b", 2, 1'b0);

    // Abort: pulse shorter than the dead time never reaches the high side.
    apb_write(32'h04, 32'h0000_020A);
    h_seen = 1'b0;
    pwm_in_tb = 1'b1;
    repeat (3) begin tick(); h_seen |= pwm_h; end
    pwm_in_tb = 1'b0;
    tick(); h_seen |= pwm_h;
    check_eq("abort_h_never", {31'd0, h_seen}, 32'd0);
    check_eq("abort_l_back", {31'd0, pwm_l}, 32'd1);

    apb_read(32'h18, rd); check_eq("unmapped_rd", rd, 32'hDEAD_BEEF);
    apb_read(32'h04, rd); check_eq("dt_rd", rd, 32'h0000_020A);
    apb_read(32'h00, rd); check_eq("ctrl_rd", rd, 32'h1);

    // Long random run: pwm_in toggles, occasional en and DT rewrites.
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 299);
      if (r < 2)      apb_write(32'h00, {31'd0, ($urandom_range(0, 4) != 0)});
      else if (r < 6) apb_write(32'h04, {16'd0, 5'd0, 3'($urandom_range(0, 7)), 5'd0, 3'($urandom_range(0, 7))});
      else begin
        if ($urandom_range(0, 7) == 0) pwm_in_tb = ~pwm_in_tb;
        tick();
      end
    end

`ifdef EF_PWMDT_FAULT_EN
    apb_write(32'h00, 32'h1);
    apb_write(32'h04, 32'h0000_0204);
    apb_write(32'h10, 32'h1);
    pwm_in_tb = 1'b1;
    wait_out("fault_h_on", 1'b1);
    fault_in_tb = 1'b1;
    repeat (3) tick();
    check_eq("fault_h_low", {31'd0, pwm_h}, 32'd0);
    check_eq("fault_l_low", {31'd0, pwm_l}, 32'd0);
    check_eq("fault_irq", {31'd0, irq}, 32'd1);
    apb_write(32'h14, 32'h1);
    repeat (3) tick();
    fault_in_tb = 1'b0;
    repeat (12) tick();
    check_eq("fault_hold_h", {31'd0, pwm_h}, 32'd0);
    check_eq("fault_hold_irq", {31'd0, irq}, 32'd1);
    apb_write(32'h14, 32'h1);
    tick();
    check_eq("fault_clr_irq", {31'd0, irq}, 32'd0);
    wait_out("fault_resume", 1'b1);
`endif

    // Asynchronous reset while the high side is driven.
    apb_write(32'h00, 32'h1);
    pwm_in_tb = 1'b1;
    wait_out("pre_rst_h", 1'b1);
    mchk = 1'b0;
    #3 PRESETn = 1'b0;
    #1;
    check_eq("async_rst_h", {31'd0, pwm_h}, 32'd0);
    check_eq("async_rst_l", {31'd0, pwm_l}, 32'd0);
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    mchk = 1'b1;
    apb_read(32'h00, rd); check_eq("post_rst_ctrl", rd, 32'd0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ef_pwm_deadtime_apb.md
EF_PWM_DEADTIME_APB -- requirements
Module: ef_pwm_deadtime_apb

Interface
REQ-001 SHALL have reset PRESETn, asynchronous, active-low; clock PCLK.
REQ-002 SHALL have ports, clock and reset first:
- PCLK  in  1  APB clock; all logic.
- PRESETn  in  1  async active-low reset.
- PADDR  in  32  byte address.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- pwm_in  in  1  PCLK-synchronous PWM from the upstream timer.
- fault_in  in  1  asynchronous external fault, active-high.
- pwm_h  out  1  high-side drive.
- pwm_l  out  1  low-side drive.
- irq  out  1  RIS & IM, OR-reduced.
REQ-003 SHALL have registers:
- CTRL 0x00 RW: [0] en.
- DT 0x04 RW: [7:0] dt_rise, [15:8] dt_fall.
- STAT 0x08 RO: [2:0] FSM state.
- RIS 0x0C RO: [0] fault.
- IM 0x10 RW.
- ICR 0x14 WO, self-clearing next cycle.
- Unmapped reads return 0xDEADBEEF.

Function
REQ-004 SHALL perform writes when PSEL&PENABLE&PWRITE; no wait states.
REQ-005 SHALL implement FSM states OFF, L_ON, DT_LH, H_ON, DT_HL, FAULT.
- Outputs are registered.
- pwm_h=1 only in H_ON; pwm_l=1 only in L_ON.
REQ-006 SHALL, in OFF with en=1, go to DT_LH if pwm_in=1, else DT_HL.
REQ-007 SHALL, in L_ON with pwm_in=1, go to DT_LH and load the 8-bit counter with max(dt_rise,1).
REQ-008 SHALL, in H_ON with pwm_in=0, go to DT_HL and load the counter with max(dt_fall,1).
REQ-009 SHALL decrement the counter in DT states.
- At count 1: DT_LH goes to H_ON, DT_HL goes to L_ON.
- Result: both outputs low for exactly max(dt,1) cycles.
REQ-010 SHALL abort on a reversing pwm_in during a DT state: DT_LH with pwm_in=0 returns to L_ON next cycle; DT_HL with pwm_in=1 returns to H_ON next cycle.
REQ-011 SHALL move from any state to OFF on en=0; this takes priority over pwm_in and is lower priority than fault.
REQ-012 SHALL never assert pwm_h and pwm_l simultaneously, under any stimulus.
REQ-013 SHALL let DT register writes take effect only at the next counter load; an in-progress dead time is unaffected.
REQ-014 SHALL have no pwm_in synchronizer; pwm_in is same-domain.

Reset
REQ-015 SHALL, on PRESETn low, set: state OFF; pwm_h=0, pwm_l=0, irq=0; all registers 0; counter 0; fault synchronizer 0.
REQ-016 SHALL, on reset mid-dead-time, drop both outputs low immediately (asynchronously).

Configuration
REQ-017 SHALL gate the fault path with macro EF_PWMDT_FAULT_EN.
- Defined:
  - fault_in passes a 2-flop synchronizer.
  - Synchronized high forces FAULT from any state within 1 cycle, with both outputs 0, and sets RIS[0].
  - FAULT exits to OFF only when ICR[0] is written 1 while the synchronized fault is 0.
  - Fault has highest priority.
- Undefined:
  - fault_in port absent; FAULT state unreachable.
  - RIS[0] reads 0; irq is constant 0.

Structure
REQ-018 SHALL hold the state enum, register offsets and the 0xDEADBEEF default in shared package ef_pwmdt_pkg.
REQ-019 SHALL put the FSM, counter and fault logic in sub-module ef_pwmdt_core; the APB top holds the registers and read mux.

Verification
REQ-020 SHALL cover these directed scenarios:
- Dead time: en=1, dt_rise=4, dt_fall=2, pwm_in 0->1 in L_ON -> pwm_l low next cycle, pwm_h high exactly 4 cycles later; 1->0 -> pwm_h low, pwm_l high 2 cycles later.
- Zero dead time: dt_rise=0 -> exactly 1 cycle with both low.
- Abort: dt_rise=10, pwm_in high for 3 cycles then low -> pwm_h never asserts; L_ON restored on the cycle after pwm_in falls.
- Fault (macro on): IM=1, fault_in pulse in H_ON -> both low within 3 cycles, irq=1; ICR=1 while fault_in high -> stays FAULT; ICR=1 after release -> OFF, irq=0.
- Reads: read 0x18 -> 0xDEADBEEF; random pwm_in/en over 10k cycles -> pwm_h&pwm_l never 1.
